// File: rtl/fiao_sched_pkg.sv
// Shared types for the FIAO issue scheduler: wrap-flagged pointer tag and
// the tag distance used to derive the occupancy count.
package fiao_sched_pkg;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    // Pointer tag: index into the pool plus a wrap flag as MSB.
    typedef struct packed {
        logic             flag;
        logic [PTR_W-1:0] idx;
    } tag_t;

    // Slots from head up to tail. Because the flag is the MSB, a plain
    // modular subtraction on PTR_W+1 bits yields 0..DEPTH.
    function automatic logic [PTR_W:0] tag_dist(input tag_t tail, input tag_t head);
        return tail - head;
    endfunction

endpackage

// File: rtl/age_oldest_picker.sv
// Combinational oldest-first picker. Entries at or above head are older
// than entries below head, so the lowest set bit of the upper region wins;
// the lower region is only consulted when the upper region is empty.
module age_oldest_picker #(
    parameter int Depth = 8,
    localparam int PtrWidth = $clog2(Depth)
) (
    input  logic [Depth-1:0]    mask,
    input  logic [PtrWidth-1:0] head,
    output logic [Depth-1:0]    oldest
);

    logic [Depth-1:0] upper;
    logic [Depth-1:0] pick_from;
    logic             found;

    // Split the mask at head, then take the lowest set bit of the chosen half.
    always_comb begin
        upper     = '0;
        oldest    = '0;
        found     = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            upper[i] = mask[i] && (PtrWidth'(i) >= head);
        end
        pick_from = (|upper) ? upper : mask;
        for (int i = 0; i < Depth; i++) begin
            if (pick_from[i] && !found) begin
                oldest[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fiao_issue_scheduler.sv
// First-in-any-out issue scheduler: in-order allocation at the tail,
// oldest-ready selection over IssueWidth lanes, and head retirement past
// entries that have already issued.
import fiao_sched_pkg::*;

module fiao_issue_scheduler #(
    parameter int Depth      = DEPTH,
    parameter int EnqWidth   = 2,
    parameter int IssueWidth = 2,
    parameter int NumWake    = 2,
    localparam int PtrWidth  = $clog2(Depth)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [EnqWidth-1:0]          enq_vld_i,
    input  logic [EnqWidth-1:0]          enq_rdy_i_bit,
    output logic [EnqWidth-1:0]          enq_rdy_o,
    output logic [EnqWidth*PtrWidth-1:0] enq_ptr_o,
    input  logic [NumWake-1:0]           wake_vld_i,
    input  logic [NumWake*PtrWidth-1:0]  wake_idx_i,
    output logic [IssueWidth-1:0]        issue_vld_o,
    output logic [IssueWidth*PtrWidth-1:0] issue_idx_o,
    input  logic [IssueWidth-1:0]        issue_rdy_i,
    input  logic                         flush_i,
    output logic [PtrWidth:0]            count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    tag_t             head_q, tail_q, head_d, tail_d;
    logic [Depth-1:0] valid_q, ready_q, valid_d, ready_d;
    logic [PtrWidth:0] count, free_slots, vld_below, fire_cnt, adv;
    logic [EnqWidth-1:0] fired;
    logic [Depth-1:0] cand, issue_clr;
    logic [PtrWidth-1:0] ret_idx;
    logic             ret_stop;

    function automatic logic [PtrWidth-1:0] oh_to_idx(input logic [Depth-1:0] oh);
        oh_to_idx = '0;
        for (int i = 0; i < Depth; i++) begin
            if (oh[i]) oh_to_idx = oh_to_idx | PtrWidth'(i);
        end
    endfunction

    assign count      = tag_dist(tail_q, head_q);
    assign count_o    = count;
    assign full_o     = (head_q.idx == tail_q.idx) && (head_q.flag != tail_q.flag);
    assign empty_o    = (head_q == tail_q);
    assign free_slots = (PtrWidth+1)'(Depth) - count;
    assign cand       = valid_q & ready_q;

    // Enqueue lanes: firing lanes are compacted onto consecutive slots; an
    // idle lane shows its uncompacted slot (tail + lane number).
    always_comb begin
        enq_rdy_o = '0;
        enq_ptr_o = '0;
        fired     = '0;
        vld_below = '0;
        fire_cnt  = '0;
        for (int i = 0; i < EnqWidth; i++) begin
            enq_rdy_o[i] = (free_slots > (PtrWidth+1)'(i)) && !flush_i;
            fired[i]     = enq_vld_i[i] && enq_rdy_o[i];
            if (enq_vld_i[i]) begin
                enq_ptr_o[i*PtrWidth +: PtrWidth] = tail_q.idx + PtrWidth'(vld_below);
                vld_below = vld_below + 1'b1;
            end else begin
                enq_ptr_o[i*PtrWidth +: PtrWidth] = tail_q.idx + PtrWidth'(i);
            end
            if (fired[i]) fire_cnt = fire_cnt + 1'b1;
        end
    end

    // Issue lanes: each picker sees the candidates left by earlier lanes and
    // accumulates the entries whose handshake completed this cycle.
    for (genvar k = 0; k < IssueWidth; k++) begin : g_pick
        logic [Depth-1:0] mask_in, oh, clr_acc;
        logic             acc;

        age_oldest_picker #(.Depth(Depth)) u_picker (
            .mask   (mask_in),
            .head   (head_q.idx),
            .oldest (oh)
        );

        assign issue_vld_o[k] = (|oh) && !flush_i;
        assign issue_idx_o[k*PtrWidth +: PtrWidth] = oh_to_idx(oh);
        assign acc = issue_vld_o[k] && issue_rdy_i[k];

        if (k == 0) begin : g_first
            assign mask_in = cand;
            assign clr_acc = acc ? oh : '0;
        end else begin : g_rest
            assign mask_in = g_pick[k-1].mask_in & ~g_pick[k-1].oh;
            assign clr_acc = g_pick[k-1].clr_acc | (acc ? oh : '0);
        end
    end

    assign issue_clr = g_pick[IssueWidth-1].clr_acc;

    // Retire: skip up to IssueWidth leading holes, never passing the tail.
    always_comb begin
        adv      = '0;
        ret_stop = 1'b0;
        ret_idx  = '0;
        for (int j = 0; j < IssueWidth; j++) begin
            ret_idx = head_q.idx + PtrWidth'(j);
            if (!ret_stop && ((PtrWidth+1)'(j) < count) && !valid_q[ret_idx]) begin
                adv = adv + 1'b1;
            end else begin
                ret_stop = 1'b1;
            end
        end
    end

    // Next state: wake, then issue clear, then enqueue (enqueue value wins).
    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        for (int w = 0; w < NumWake; w++) begin
            if (wake_vld_i[w] && valid_q[wake_idx_i[w*PtrWidth +: PtrWidth]]) begin
                ready_d[wake_idx_i[w*PtrWidth +: PtrWidth]] = 1'b1;
            end
        end
        valid_d = valid_d & ~issue_clr;
        ready_d = ready_d & ~issue_clr;
        for (int i = 0; i < EnqWidth; i++) begin
            if (fired[i]) begin
                valid_d[enq_ptr_o[i*PtrWidth +: PtrWidth]] = 1'b1;
                ready_d[enq_ptr_o[i*PtrWidth +: PtrWidth]] = enq_rdy_i_bit[i];
            end
        end
        head_d = tag_t'(head_q + adv);
        tail_d = tag_t'(tail_q + fire_cnt);
        if (flush_i) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_fiao_issue_scheduler.sv
// Scoreboard bench for fiao_issue_scheduler (Depth=8, 2 enqueue, 2 issue lanes).
module tb_fiao_issue_scheduler;

    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [1:0]    enq_vld_i, enq_rdy_i_bit, enq_rdy_o;
    logic [2*PW-1:0] enq_ptr_o;
    logic [1:0]    wake_vld_i;
    logic [2*PW-1:0] wake_idx_i;
    logic [1:0]    issue_vld_o, issue_rdy_i;
    logic [2*PW-1:0] issue_idx_o;
    logic          flush_i;
    logic [PW:0]   count_o;
    logic          full_o, empty_o;

    fiao_issue_scheduler dut (
        .clk           (clk),
        .rstn          (rstn),
        .enq_vld_i     (enq_vld_i),
        .enq_rdy_i_bit (enq_rdy_i_bit),
        .enq_rdy_o     (enq_rdy_o),
        .enq_ptr_o     (enq_ptr_o),
        .wake_vld_i    (wake_vld_i),
        .wake_idx_i    (wake_idx_i),
        .issue_vld_o   (issue_vld_o),
        .issue_idx_o   (issue_idx_o),
        .issue_rdy_i   (issue_rdy_i),
        .flush_i       (flush_i),
        .count_o       (count_o),
        .full_o        (full_o),
        .empty_o       (empty_o)
    );

    always #5 clk = ~clk;

    // Observation layout: cnt[21:18] full[17] empty[16] rdy[15:14]
    // ptr1[13:11] ptr0[10:8] iv[7:6] idx1[5:3] idx0[2:0]
    typedef struct {
        int          cyc;
        string       name;
        logic [21:0] obs;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Cycle index used to tag expectations.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop expectations due this cycle and compare mid-cycle.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [21:0] act, ex;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e   = exp_q.pop_front();
            act = {count_o, full_o, empty_o, enq_rdy_o, enq_ptr_o, issue_vld_o, issue_idx_o};
            ex  = e.obs;
            if (!ex[7]) begin act[5:3] = '0; ex[5:3] = '0; end
            if (!ex[6]) begin act[2:0] = '0; ex[2:0] = '0; end
            n_cmp++;
            if (act !== ex || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got cnt=%0d full=%b empty=%b rdy=%b ptr1/0=%0d/%0d iv=%b idx1/0=%0d/%0d, want cnt=%0d full=%b empty=%b rdy=%b ptr1/0=%0d/%0d iv=%b idx1/0=%0d/%0d",
                         e.name, cyc,
                         act[21:18], act[17], act[16], act[15:14], act[13:11], act[10:8], act[7:6], act[5:3], act[2:0],
                         ex[21:18], ex[17], ex[16], ex[15:14], ex[13:11], ex[10:8], ex[7:6], ex[5:3], ex[2:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] vld, input logic [1:0] rb, input logic [1:0] wv,
                          input int wi1, input int wi0, input logic [1:0] ir, input logic fl);
        enq_vld_i     = vld;
        enq_rdy_i_bit = rb;
        wake_vld_i    = wv;
        wake_idx_i    = {PW'(wi1), PW'(wi0)};
        issue_rdy_i   = ir;
        flush_i       = fl;
    endtask

    task automatic expect_obs(input string name, input int cnt, input logic full, input logic empty,
                              input logic [1:0] rdy, input int p1, input int p0,
                              input logic [1:0] iv, input int i1, input int i0);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.obs  = {4'(cnt), full, empty, rdy, 3'(p1), 3'(p0), iv, 3'(i1), 3'(i0)};
        exp_q.push_back(e);
    endtask

    initial begin
        set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        expect_obs("reset",       0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);

        // Four ready entries, partial acceptance, head retirement.
        next_cycle(); set_in(2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("a_enq0",      0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);
        next_cycle(); set_in(2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("a_enq1",      2, 0, 0, 2'b11, 3, 2, 2'b11, 1, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b10, 0);
        expect_obs("a_sel01",     4, 0, 0, 2'b11, 5, 4, 2'b11, 1, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("a_resel02",   4, 0, 0, 2'b11, 5, 4, 2'b11, 2, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0);
        expect_obs("a_acc0",      4, 0, 0, 2'b11, 5, 4, 2'b11, 2, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("a_hole",      4, 0, 0, 2'b11, 5, 4, 2'b11, 3, 2);
        next_cycle();
        expect_obs("a_retired",   2, 0, 0, 2'b11, 5, 4, 2'b11, 3, 2);
        next_cycle(); set_in(2'b11, 2'b11, 2'b00, 0, 0, 2'b11, 1);
        expect_obs("a_flush",     2, 0, 0, 2'b00, 5, 4, 2'b00, 0, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("a_empty",     0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);

        // Fill with not-ready entries, then wake index 5.
        next_cycle(); set_in(2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("b_fill0",     0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);
        next_cycle();
        expect_obs("b_fill1",     2, 0, 0, 2'b11, 3, 2, 2'b00, 0, 0);
        next_cycle();
        expect_obs("b_fill2",     4, 0, 0, 2'b11, 5, 4, 2'b00, 0, 0);
        next_cycle();
        expect_obs("b_fill3",     6, 0, 0, 2'b11, 7, 6, 2'b00, 0, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b01, 0, 5, 2'b00, 0);
        expect_obs("b_full",      8, 1, 0, 2'b00, 1, 0, 2'b00, 0, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 0);
        expect_obs("b_wake5",     8, 1, 0, 2'b00, 1, 0, 2'b01, 0, 5);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("b_hole_kept", 8, 1, 0, 2'b00, 1, 0, 2'b00, 0, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 1);
        expect_obs("w_flush",     8, 1, 0, 2'b00, 1, 0, 2'b00, 0, 0);

        // Walk head to 6 and tail to 2 with the wrap flag set.
        next_cycle(); set_in(2'b11, 2'b11, 2'b00, 0, 0, 2'b11, 0);
        expect_obs("w_e0",        0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);
        next_cycle();
        expect_obs("w_e1",        2, 0, 0, 2'b11, 3, 2, 2'b11, 1, 0);
        next_cycle();
        expect_obs("w_e2",        4, 0, 0, 2'b11, 5, 4, 2'b11, 3, 2);
        next_cycle(); set_in(2'b11, 2'b00, 2'b00, 0, 0, 2'b11, 0);
        expect_obs("w_e3",        4, 0, 0, 2'b11, 7, 6, 2'b11, 5, 4);
        next_cycle(); set_in(2'b11, 2'b10, 2'b10, 7, 0, 2'b00, 0);
        expect_obs("w_e4",        4, 0, 0, 2'b11, 1, 0, 2'b00, 0, 0);
        next_cycle(); set_in(2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0);
        expect_obs("w_wrap",      4, 0, 0, 2'b11, 3, 2, 2'b11, 1, 7);

        // Asynchronous reset in the middle of a cycle.
        next_cycle();
        rstn = 1'b0;
        expect_obs("mid_reset",   0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);
        next_cycle();
        rstn = 1'b1;
        expect_obs("post_reset",  0, 0, 1, 2'b11, 1, 0, 2'b00, 0, 0);

        next_cycle();
        next_cycle();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: %0d expectations never compared, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fiao_issue_scheduler.md
# fiao_issue_scheduler

Controller for a first-in-any-out (FIAO) entry pool. It allocates entries in order at the tail and tracks per-entry valid and ready state. Each cycle it picks the oldest ready entries, up to IssueWidth, and hands them out over per-lane valid/ready handshakes. It retires the head past freed entries so their slots can be reused. It sits between dispatch, which enqueues, the wakeup network, and the issue ports of a reservation-station-style buffer, and owns all pointer and age bookkeeping for that buffer.

## Interface
- Depth, 8: entry count, power of two ≥ 2.
- EnqWidth, 2: enqueue lanes, ≤ Depth.
- IssueWidth, 2: issue lanes, ≤ Depth.
- NumWake, 2: wakeup ports.
- PtrWidth, $clog2(Depth): local, index width.

Ports:
- clk  in  1  clock, single domain.
- rstn  in  1  asynchronous active-low reset.
- enq_vld_i  in  EnqWidth  enqueue request per lane.
- enq_rdy_i_bit  in  EnqWidth  entry already ready at enqueue.
- enq_rdy_o  out  EnqWidth  lane may enqueue this cycle.
- enq_ptr_o  out  EnqWidth*PtrWidth  index allocated to each lane.
- wake_vld_i  in  NumWake  wakeup strobe.
- wake_idx_i  in  NumWake*PtrWidth  entry index to mark ready.
- issue_vld_o  out  IssueWidth  lane carries a selected entry.
- issue_idx_o  out  IssueWidth*PtrWidth  selected entry index.
- issue_rdy_i  in  IssueWidth  consumer accepts lane.
- flush_i  in  1  synchronous clear of all entries.
- count_o  out  PtrWidth+1  slots between head and tail, including holes.
- full_o  out  1  count_o == Depth.
- empty_o  out  1  count_o == 0.

## Operation
- State:
  - head pointer and tail pointer, each PtrWidth bits plus a wrap flag.
  - valid[Depth], ready[Depth].
- count = tail − head, computed on PtrWidth+1 bits with the flag as MSB.
- full when pointers are equal and flags differ; empty when pointers and flags are equal.
- Enqueue:
  - enq_rdy_o[i] = (Depth − count > i) & ~flush_i.
  - Lane i fires on enq_vld_i[i] & enq_rdy_o[i].
  - enq_ptr_o[i] = tail + popcount(enq_vld_i[i−1:0]) mod Depth, so firing lanes are compacted.
  - Each fired entry sets valid=1 and ready=enq_rdy_i_bit[i].
  - tail advances by popcount(fired); the flag toggles on wrap.
- Wakeup:
  - Sets ready[wake_idx_i] when that entry is valid in registered state.
  - A wake to an invalid entry is ignored.
  - A wake to an entry enqueued in the same cycle is ignored; the enqueue value wins.
- Selection:
  - Candidate set = valid & ready.
  - Age order runs from head up to Depth−1, then 0 up to tail−1.
  - Lane k gets the k-th oldest candidate; issue_vld_o[k]=0 if none exists.
  - Selection is combinational from registered state.
  - All issue_vld_o are forced to 0 while flush_i is high.
- Issue handshake:
  - On issue_vld_o[k] & issue_rdy_i[k], the entry's valid and ready bits are cleared at the next edge.
  - An unaccepted entry stays put and may be reselected next cycle, possibly on a different lane.
- Retire:
  - When not empty, head advances over up to IssueWidth consecutive entries starting at head whose registered valid bit is 0, stopping at tail.
  - Holes behind the head are not reused until the head passes them.
- Flush: at the next edge, valid and ready are cleared and both pointers and flags return to 0. Enqueues in the flush cycle are dropped.

## Timing
- Reset values:
  - head, tail, flags = 0; valid and ready = 0.
  - count_o=0, empty_o=1, full_o=0, issue_vld_o=0, enq_rdy_o = all ones.
  - enq_ptr_o lane i = i.
- Enqueue with enq_rdy_i_bit=1 in cycle N → eligible for issue in N+1.
- Wake in cycle N → eligible in N+1.
- Issue accepted in N → valid clears at end of N → head may advance at end of N+1 → freed slot visible on enq_rdy_o in N+2.
- Enqueue, wake, issue and retire may all occur in one cycle. Each acts on registered state; next state is their union.
- Reset asserted mid-operation returns all state to reset values immediately. Reset is asynchronous; deassertion is synchronous to clk.

## Structure
- Shared package fiao_sched_pkg: the ptr/tag typedef (flag + index) and the tag-distance function used for count.
- Sub-module age_oldest_picker: a combinational head/tail split priority picker that returns the one-hot oldest bit of a mask given head. It is instantiated IssueWidth times, chained by masking out earlier picks.

## Test plan
Depth=8, EnqWidth=2, IssueWidth=2 throughout.
- Reset → count_o=0, empty_o=1, enq_rdy_o=2'b11, enq_ptr_o={1,0}, issue_vld_o=0.
- Enqueue 4 entries, all ready, with issue_rdy_i=0 → issue lanes show idx 0 and 1. Accept lane 1 only → next cycle lanes show 0 and 2.
- Fill with 8 not-ready entries → full_o=1, enq_rdy_o=0. Wake idx 5 → next cycle lane 0 shows idx 5.
- Wrap: head=6, tail=2 with flag set, entries 7 and 1 ready → lane 0 shows idx 7, lane 1 shows idx 1.
- Issue idx 0 and 1 in cycle N → head=2 at end of N+1, count_o drops by 2 in N+2.
- Flush_i together with enq_vld_i=2'b11 → next cycle empty_o=1, pointers at 0, no entry is valid.
